// File: rtl/fxfl_pkg.sv
// Shared constants and types for the fixed/float conversion scheduler.
package fxfl_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int POS_W_DEF  = 5;

  localparam logic OP_FIX2FLT = 1'b0;
  localparam logic OP_FLT2FIX = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester not granted last wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last)) gnt = 2'b01;
    else if (req[1])                 gnt = 2'b10;
  end
endmodule

// File: rtl/fixfloat_sched.sv
// Two-requester scheduler for a single fixed<->float converter, one job in flight.
// Optional watchdog in WAIT enabled by defining FXFL_TIMEOUT_EN.
module fixfloat_sched
  import fxfl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int POS_W       = POS_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_num,
  input  logic [DATA_W-1:0] req1_num,
  input  logic [POS_W-1:0]  req0_pos,
  input  logic [POS_W-1:0]  req1_pos,
  input  logic              req0_op,
  input  logic              req1_op,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err,
  output logic              cv_start,
  output logic [DATA_W-1:0] cv_targetnumber,
  output logic [POS_W-1:0]  cv_fixpointpos,
  output logic              cv_opcode,
  input  logic              cv_done,
  input  logic [DATA_W-1:0] cv_result
);
  state_t     state;
  logic       last;
  logic       job_id;
  logic [1:0] gnt;
  logic       wd_exp;

  rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (last),
    .gnt  (gnt)
  );

  assign req0_ready = (state == IDLE) && gnt[0];
  assign req1_ready = (state == IDLE) && gnt[1];

`ifdef FXFL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;

  // wd_cnt holds the number of completed WAIT cycles; expiry on the last allowed one
  assign wd_exp = (state == WAIT) && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               wd_cnt <= '0;
    else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
    else                    wd_cnt <= '0;
  end
`else
  // watchdog compiled out; the parameter stays so both builds share one interface
  assign wd_exp = 1'b0 & (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      last            <= 1'b1;
      job_id          <= 1'b0;
      cv_start        <= 1'b0;
      cv_targetnumber <= '0;
      cv_fixpointpos  <= '0;
      cv_opcode       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_id          <= 1'b0;
      rsp_result      <= '0;
      rsp_err         <= 1'b0;
    end else begin
      cv_start  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (|gnt) begin
          cv_targetnumber <= gnt[1] ? req1_num : req0_num;
          cv_fixpointpos  <= gnt[1] ? req1_pos : req0_pos;
          cv_opcode       <= gnt[1] ? req1_op  : req0_op;
          job_id          <= gnt[1];
          cv_start        <= 1'b1;
          state           <= ISSUE;
        end
        ISSUE: state <= WAIT;
        // a result arriving on the expiry cycle takes priority over the timeout
        WAIT: if (cv_done) begin
          rsp_result <= cv_result;
          rsp_err    <= 1'b0;
          rsp_id     <= job_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end else if (wd_exp) begin
          rsp_result <= '0;
          rsp_err    <= 1'b1;
          rsp_id     <= job_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          last  <= rsp_id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
